// File: rtl/serial_add_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and limits for the bit-serial adder sequencer.
//               sa_state_t    - sequencer FSM encoding (IDLE, RUN, DONE)
//               SA_MAX_WIDTH  - widest operand the sequencer supports
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fa_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_bit
// Description : Purely combinational 1-bit full adder.
//               i_a, i_b, i_cin : addend bits and carry-in
//               o_s             : sum bit
//               o_c             : carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_cin;
  assign o_c = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : fa_bit
`default_nettype wire

// File: rtl/serial_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial adder sequencer. Accepts two WIDTH-bit operands
//               plus carry-in, runs them LSB-first through a single fa_bit
//               cell over WIDTH cycles, and presents sum + carry-out on a
//               valid/ready handshake.
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start_valid  in   1      operands presented
//   start_ready  out  1      accepting operands (IDLE only)
//   a_in, b_in   in   WIDTH  operands, sampled on accept
//   cin_in       in   1      carry-in, sampled on accept
//   done_valid   out  1      sum_out/cout_out valid (DONE)
//   done_ready   in   1      consumer takes result
//   sum_out      out  WIDTH  (a+b+cin) mod 2^WIDTH, held until next result
//   cout_out     out  1      carry out of bit WIDTH-1
//   busy         out  1      RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  generate
    if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
      $error("serial_add_seq: WIDTH out of range");
    end
  endgenerate

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;

  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_sum_next;

  fa_bit u_fa_bit (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_cin (r_carry),
    .o_s   (w_fa_s),
    .o_c   (w_fa_c)
  );

  assign w_last_bit = (r_bit_cnt == c_last_bit);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_fa_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_fa_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start_valid) w_state_next = RUN;
      RUN:     if (w_last_bit)  w_state_next = DONE;
      // Returning to IDLE here means no accept can coincide with the take.
      DONE:    if (done_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_bit_cnt  <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a_sh    <= a_in;
            r_b_sh    <= b_in;
            r_carry   <= cin_in;
            r_bit_cnt <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_c;
          if (w_last_bit) begin
            r_sum_out  <= w_sum_next;
            r_cout_out <= w_fa_c;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign done_valid  = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign sum_out     = r_sum_out;
  assign cout_out    = r_cout_out;

endmodule : serial_add_seq
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=1
//               using directed vectors and randomised operands/stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

  logic clk;
  logic rst_n;

  // WIDTH=8 instance
  logic       s8_start_valid, s8_start_ready, s8_cin, s8_done_valid, s8_done_ready;
  logic       s8_cout, s8_busy;
  logic [7:0] s8_a, s8_b, s8_sum;

  // WIDTH=1 instance
  logic       s1_start_valid, s1_start_ready, s1_cin, s1_done_valid, s1_done_ready;
  logic       s1_cout, s1_busy;
  logic [0:0] s1_a, s1_b, s1_sum;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (s8_start_valid),
    .start_ready (s8_start_ready),
    .a_in        (s8_a),
    .b_in        (s8_b),
    .cin_in      (s8_cin),
    .done_valid  (s8_done_valid),
    .done_ready  (s8_done_ready),
    .sum_out     (s8_sum),
    .cout_out    (s8_cout),
    .busy        (s8_busy)
  );

  serial_add_seq #(.WIDTH(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (s1_start_valid),
    .start_ready (s1_start_ready),
    .a_in        (s1_a),
    .b_in        (s1_b),
    .cin_in      (s1_cin),
    .done_valid  (s1_done_valid),
    .done_ready  (s1_done_ready),
    .sum_out     (s1_sum),
    .cout_out    (s1_cout),
    .busy        (s1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; returns {cout,sum} and the number of cycles
  // from the accept edge to the first sample with done_valid high.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input int stall, output logic [8:0] res, output int lat);
    int n;
    logic [7:0] held;
    n = 0;
    while (!s8_start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s8_start_ready) check("w8_ready_timeout", 64'(s8_start_ready), 64'd1);
    s8_a = a; s8_b = b; s8_cin = cin; s8_start_valid = 1'b1;
    @(posedge clk);
    #1 s8_start_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s8_done_valid && lat < 100);
    res  = {s8_cout, s8_sum};
    held = s8_sum;
    for (int i = 0; i < stall; i++) begin
      check("w8_stall_valid", 64'(s8_done_valid), 64'd1);
      check("w8_stall_ready", 64'(s8_start_ready), 64'd0);
      check("w8_stall_sum", 64'(s8_sum), 64'(held));
      @(negedge clk);
    end
    s8_done_ready = 1'b1;
    @(posedge clk);
    #1 s8_done_ready = 1'b0;
    @(negedge clk);
    check("w8_idle_after_take", 64'(s8_start_ready), 64'd1);
  endtask

  task automatic add1(input logic a, input logic b, input logic cin,
                      input int stall, output logic [1:0] res, output int lat);
    int n;
    n = 0;
    while (!s1_start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s1_start_ready) check("w1_ready_timeout", 64'(s1_start_ready), 64'd1);
    s1_a = a; s1_b = b; s1_cin = cin; s1_start_valid = 1'b1;
    @(posedge clk);
    #1 s1_start_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s1_done_valid && lat < 100);
    res = {s1_cout, s1_sum};
    for (int i = 0; i < stall; i++) begin
      check("w1_stall_valid", 64'(s1_done_valid), 64'd1);
      @(negedge clk);
    end
    s1_done_ready = 1'b1;
    @(posedge clk);
    #1 s1_done_ready = 1'b0;
    @(negedge clk);
    check("w1_idle_after_take", 64'(s1_start_ready), 64'd1);
  endtask

  initial begin
    logic [8:0] r8;
    logic [1:0] r1;
    logic [7:0] ra, rb;
    logic       rc;
    int         lat;
    int         n;

    rst_n = 1'b0;
    s8_start_valid = 0; s8_a = 0; s8_b = 0; s8_cin = 0; s8_done_ready = 0;
    s1_start_valid = 0; s1_a = 0; s1_b = 0; s1_cin = 0; s1_done_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_done_valid", 64'(s8_done_valid), 64'd0);
    check("rst_busy", 64'(s8_busy), 64'd0);
    check("rst_sum", 64'(s8_sum), 64'd0);
    check("rst_cout", 64'(s8_cout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready", 64'(s8_start_ready), 64'd1);

    // Directed WIDTH=8 vectors
    add8(8'hFF, 8'h01, 1'b0, 0, r8, lat);
    check("ff_01_sum", 64'(r8), 64'h100);
    check("ff_01_latency", 64'(lat), 64'd9);
    add8(8'hA5, 8'h5A, 1'b1, 0, r8, lat);
    check("a5_5a_sum", 64'(r8), 64'h100);
    add8(8'h12, 8'h34, 1'b0, 0, r8, lat);
    check("12_34_sum", 64'(r8), 64'h046);

    // Backpressure: five stalled cycles in DONE
    add8(8'h80, 8'h80, 1'b1, 5, r8, lat);
    check("bp_sum", 64'(r8), 64'h101);

    // Reset in the middle of RUN
    s8_a = 8'h0F; s8_b = 8'h0F; s8_cin = 1'b0; s8_start_valid = 1'b1;
    @(posedge clk);
    #1 s8_start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy", 64'(s8_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", 64'(s8_done_valid), 64'd0);
    check("midrun_rst_busy", 64'(s8_busy), 64'd0);
    check("midrun_rst_sum", 64'(s8_sum), 64'd0);
    check("midrun_rst_cout", 64'(s8_cout), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_rel_ready", 64'(s8_start_ready), 64'd1);
    add8(8'd3, 8'd4, 1'b0, 0, r8, lat);
    check("after_rst_3_4", 64'(r8), 64'h007);

    // start_valid held high with changing operands during RUN/DONE
    s8_a = 8'h10; s8_b = 8'h20; s8_cin = 1'b0; s8_start_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      s8_a = s8_a + 8'h11;
      s8_b = ~s8_b;
      n++;
    end while (!s8_done_valid && n < 100);
    check("ignore_sum", 64'({s8_cout, s8_sum}), 64'h030);
    s8_done_ready = 1'b1;
    @(posedge clk);
    #1 s8_done_ready = 1'b0;
    @(negedge clk);
    check("no_accept_in_done_ready", 64'(s8_start_ready), 64'd1);
    check("no_accept_in_done_busy", 64'(s8_busy), 64'd0);
    s8_start_valid = 1'b0;

    // Random WIDTH=8 with stalls
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8(ra, rb, rc, int'($urandom_range(0, 3)), r8, lat);
      check("rand8_sum", 64'(r8), 64'({1'b0, ra} + {1'b0, rb} + {8'd0, rc}));
    end

    // WIDTH=1
    add1(1'b1, 1'b1, 1'b1, 0, r1, lat);
    check("w1_111_sum", 64'(r1), 64'h3);
    check("w1_latency", 64'(lat), 64'd2);
    add1(1'b1, 1'b0, 1'b0, 2, r1, lat);
    check("w1_100_sum", 64'(r1), 64'h1);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 1));
      rb = 8'($urandom_range(0, 1));
      rc = 1'($urandom);
      add1(ra[0], rb[0], rc, int'($urandom_range(0, 2)), r1, lat);
      check("rand1_sum", 64'(r1), 64'(ra + rb + {7'd0, rc}));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_add_seq
`default_nettype wire
